// File: rtl/adc_fifo_rd_ctrl.sv
// -----------------------------------------------------------------------------
// adc_fifo_rd_ctrl
//
// Read-side controller for the ADC dual-clock FIFO. It runs entirely in the
// CPU clock domain, so every FIFO status input used here is already in this
// domain.
//
// Start-up runs CLEAR -> SETTLE -> PRIME -> RUN. CLEAR holds the FIFO
// asynchronous clear. SETTLE waits for the write side to recover. PRIME waits
// for a minimum fill level. RUN streams samples to the demodulator with a
// one-cycle valid strobe.
//
// An rdfull seen in RUN counts as an overflow. Depending on AUTO_RECOVER, the
// controller then either re-initialises the FIFO or parks in ERR until the
// enable is dropped.
//
// Parameters
//   DATA_WIDTH     ADC sample width (FIFO q width)
//   USEDW_W        width of FIFO rdusedw
//   CLR_CYCLES     cycles o_fifo_aclr is held high in CLEAR (>=1)
//   SETTLE_CYCLES  cycles spent in SETTLE after aclr release (>=1)
//   PRIME_LEVEL    rdusedw level needed to enter RUN (0 = enter RUN at once)
//   AUTO_RECOVER   1: overflow -> CLEAR, 0: overflow -> ERR until i_en low
//   CNT_W          width of the overflow and sample counters
//
// Ports
//   i_clk            CPU clock
//   i_rst            synchronous reset, active high
//   i_en             enable streaming; low returns to IDLE from any state
//   i_fifo_q         FIFO read data, valid the cycle after rdreq
//   i_fifo_rdempty   FIFO empty flag (read domain)
//   i_fifo_rdfull    FIFO full flag (read domain)
//   i_fifo_rdusedw   FIFO fill level (read domain)
//   o_fifo_rdreq     FIFO read request (combinational)
//   o_fifo_aclr      FIFO clear, registered, high exactly while in CLEAR
//   o_data           sample to demodulator, holds when o_vld is low
//   o_vld            one-cycle strobe qualifying o_data
//   o_running        high while in RUN
//   o_err            high while in ERR
//   o_state          IDLE=0 CLEAR=1 SETTLE=2 PRIME=3 RUN=4 ERR=5
//   o_ovf_cnt        overflow events, saturating
//   o_sample_cnt     samples delivered, wraps
// -----------------------------------------------------------------------------
module adc_fifo_rd_ctrl #(
    parameter int DATA_WIDTH    = 14,
    parameter int USEDW_W       = 4,
    parameter int CLR_CYCLES    = 4,
    parameter int SETTLE_CYCLES = 8,
    parameter int PRIME_LEVEL   = 4,
    parameter int AUTO_RECOVER  = 1,
    parameter int CNT_W         = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_en,
    input  logic [DATA_WIDTH-1:0] i_fifo_q,
    input  logic                  i_fifo_rdempty,
    input  logic                  i_fifo_rdfull,
    input  logic [USEDW_W-1:0]    i_fifo_rdusedw,
    output logic                  o_fifo_rdreq,
    output logic                  o_fifo_aclr,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_vld,
    output logic                  o_running,
    output logic                  o_err,
    output logic [2:0]            o_state,
    output logic [CNT_W-1:0]      o_ovf_cnt,
    output logic [CNT_W-1:0]      o_sample_cnt
);

    // One shared down-counter serves both CLEAR and SETTLE. It is loaded
    // with (length - 1), and its terminal count is zero.
    localparam int TMR_MAX = (CLR_CYCLES > SETTLE_CYCLES) ? CLR_CYCLES : SETTLE_CYCLES;
    localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

    localparam logic [TMR_W-1:0] CLR_LOAD    = TMR_W'(CLR_CYCLES - 1);
    localparam logic [TMR_W-1:0] SETTLE_LOAD = TMR_W'(SETTLE_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_PRIME  = 3'd3,
        ST_RUN    = 3'd4,
        ST_ERR    = 3'd5
    } state_t;

    state_t                  state_reg;
    logic [TMR_W-1:0]        timer_reg;
    logic                    aclr_reg;
    logic                    running_reg;
    logic                    err_reg;
    logic [CNT_W-1:0]        ovf_cnt_reg;

    logic                    rd_d1_reg;      // read issued last cycle, q valid now
    logic                    vld_reg;
    logic [DATA_WIDTH-1:0]   data_reg;
    logic [CNT_W-1:0]        sample_cnt_reg;

    logic                    rdreq;
    logic                    prime_ok;
    logic                    ovf_event;

    // Reads are gated by i_en directly, not only by the state. A read is
    // therefore never issued in the cycle in which the enable drops, even
    // though the state only leaves RUN at the following edge.
    assign rdreq     = i_en & ~i_fifo_rdempty & (state_reg == ST_RUN);
    assign ovf_event = (state_reg == ST_RUN) & i_fifo_rdfull;

    // PRIME exit condition. A zero level means "do not wait for data".
    generate
        if (PRIME_LEVEL == 0) begin : g_prime_none
            logic unused_usedw;
            assign unused_usedw = ^i_fifo_rdusedw;
            assign prime_ok     = 1'b1;
        end else begin : g_prime_level
            localparam logic [USEDW_W:0] PRIME_LVL = (USEDW_W + 1)'(PRIME_LEVEL);
            assign prime_ok = ({1'b0, i_fifo_rdusedw} >= PRIME_LVL) & ~i_fifo_rdempty;
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Control FSM. The flags aclr/running/err are written alongside every
    // state change, so they line up exactly with the state they decode.
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg   <= ST_IDLE;
            timer_reg   <= '0;
            aclr_reg    <= 1'b0;
            running_reg <= 1'b0;
            err_reg     <= 1'b0;
            ovf_cnt_reg <= '0;
        end else begin
            // Overflow is counted even when the enable drops in the same
            // cycle, so this sits outside the i_en priority check below.
            if (ovf_event && (ovf_cnt_reg != {CNT_W{1'b1}})) begin
                ovf_cnt_reg <= ovf_cnt_reg + 1'b1;
            end

            if (!i_en) begin
                state_reg   <= ST_IDLE;
                aclr_reg    <= 1'b0;
                running_reg <= 1'b0;
                err_reg     <= 1'b0;
            end else begin
                case (state_reg)
                    ST_IDLE: begin
                        state_reg <= ST_CLEAR;
                        timer_reg <= CLR_LOAD;
                        aclr_reg  <= 1'b1;
                    end

                    ST_CLEAR: begin
                        if (timer_reg == '0) begin
                            state_reg <= ST_SETTLE;
                            timer_reg <= SETTLE_LOAD;
                            aclr_reg  <= 1'b0;
                        end else begin
                            timer_reg <= timer_reg - 1'b1;
                        end
                    end

                    ST_SETTLE: begin
                        if (timer_reg == '0) begin
                            state_reg <= ST_PRIME;
                        end else begin
                            timer_reg <= timer_reg - 1'b1;
                        end
                    end

                    ST_PRIME: begin
                        if (prime_ok) begin
                            state_reg   <= ST_RUN;
                            running_reg <= 1'b1;
                        end
                    end

                    ST_RUN: begin
                        if (i_fifo_rdfull) begin
                            running_reg <= 1'b0;
                            if (AUTO_RECOVER != 0) begin
                                state_reg <= ST_CLEAR;
                                timer_reg <= CLR_LOAD;
                                aclr_reg  <= 1'b1;
                            end else begin
                                state_reg <= ST_ERR;
                                err_reg   <= 1'b1;
                            end
                        end
                    end

                    ST_ERR: begin
                        // Parked until i_en goes low.
                        err_reg <= 1'b1;
                    end

                    default: begin
                        state_reg   <= ST_IDLE;
                        aclr_reg    <= 1'b0;
                        running_reg <= 1'b0;
                        err_reg     <= 1'b0;
                    end
                endcase
            end
        end
    end

    // -------------------------------------------------------------------------
    // Read pipeline. The request is delayed one cycle to line up with q, and
    // then q is captured into the output register. This gives a latency of
    // two cycles from rdreq to o_vld. Only reset discards reads in flight;
    // leaving RUN lets them finish.
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rd_d1_reg      <= 1'b0;
            vld_reg        <= 1'b0;
            data_reg       <= '0;
            sample_cnt_reg <= '0;
        end else begin
            rd_d1_reg <= rdreq;
            vld_reg   <= rd_d1_reg;
            if (rd_d1_reg) begin
                data_reg       <= i_fifo_q;
                sample_cnt_reg <= sample_cnt_reg + 1'b1;
            end
        end
    end

    assign o_fifo_rdreq = rdreq;
    assign o_fifo_aclr  = aclr_reg;
    assign o_data       = data_reg;
    assign o_vld        = vld_reg;
    assign o_running    = running_reg;
    assign o_err        = err_reg;
    assign o_state      = state_reg;
    assign o_ovf_cnt    = ovf_cnt_reg;
    assign o_sample_cnt = sample_cnt_reg;

endmodule

// File: tb/tb_adc_fifo_rd_ctrl.sv
// -----------------------------------------------------------------------------
// tb_adc_fifo_rd_ctrl
//
// Two controller instances share one set of inputs:
//   dut_a - default parameters (auto-recover)
//   dut_b - AUTO_RECOVER=0, CLR/SETTLE=1, PRIME_LEVEL=0, 3-bit counters
// The 'sel' signal picks the instance that the FIFO model and the checks
// follow. A behavioural FIFO pops a word for each observed rdreq and presents
// it on q the next cycle. Each popped word is pushed to a scoreboard and is
// checked against o_data/o_vld, including the 2-cycle latency.
// Inputs change 1 time unit after posedge; outputs are sampled at negedge.
// -----------------------------------------------------------------------------
module tb_adc_fifo_rd_ctrl;

    localparam int DW = 14;
    localparam int UW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          i_rst, i_en, i_fifo_rdempty, i_fifo_rdfull;
    logic [DW-1:0] i_fifo_q;
    logic [UW-1:0] i_fifo_rdusedw;

    logic          a_rdreq, a_aclr, a_vld, a_running, a_err;
    logic [DW-1:0] a_data;
    logic [2:0]    a_state;
    logic [15:0]   a_ovf, a_scnt;

    logic          b_rdreq, b_aclr, b_vld, b_running, b_err;
    logic [DW-1:0] b_data;
    logic [2:0]    b_state;
    logic [2:0]    b_ovf, b_scnt;

    adc_fifo_rd_ctrl dut_a (
        .i_clk(clk), .i_rst(i_rst), .i_en(i_en), .i_fifo_q(i_fifo_q),
        .i_fifo_rdempty(i_fifo_rdempty), .i_fifo_rdfull(i_fifo_rdfull),
        .i_fifo_rdusedw(i_fifo_rdusedw), .o_fifo_rdreq(a_rdreq),
        .o_fifo_aclr(a_aclr), .o_data(a_data), .o_vld(a_vld),
        .o_running(a_running), .o_err(a_err), .o_state(a_state),
        .o_ovf_cnt(a_ovf), .o_sample_cnt(a_scnt)
    );

    adc_fifo_rd_ctrl #(
        .CLR_CYCLES(1), .SETTLE_CYCLES(1), .PRIME_LEVEL(0),
        .AUTO_RECOVER(0), .CNT_W(3)
    ) dut_b (
        .i_clk(clk), .i_rst(i_rst), .i_en(i_en), .i_fifo_q(i_fifo_q),
        .i_fifo_rdempty(i_fifo_rdempty), .i_fifo_rdfull(i_fifo_rdfull),
        .i_fifo_rdusedw(i_fifo_rdusedw), .o_fifo_rdreq(b_rdreq),
        .o_fifo_aclr(b_aclr), .o_data(b_data), .o_vld(b_vld),
        .o_running(b_running), .o_err(b_err), .o_state(b_state),
        .o_ovf_cnt(b_ovf), .o_sample_cnt(b_scnt)
    );

    // Outputs of the selected instance
    logic          sel;
    logic          m_rdreq, m_aclr, m_vld, m_running, m_err;
    logic [DW-1:0] m_data;
    logic [2:0]    m_state;
    logic [15:0]   m_ovf, m_scnt;
    int            cnt_mask;

    always_comb begin
        m_rdreq   = sel ? b_rdreq   : a_rdreq;
        m_aclr    = sel ? b_aclr    : a_aclr;
        m_vld     = sel ? b_vld     : a_vld;
        m_running = sel ? b_running : a_running;
        m_err     = sel ? b_err     : a_err;
        m_data    = sel ? b_data    : a_data;
        m_state   = sel ? b_state   : a_state;
        m_ovf     = sel ? {13'd0, b_ovf}  : a_ovf;
        m_scnt    = sel ? {13'd0, b_scnt} : a_scnt;
        cnt_mask  = sel ? 7 : 65535;
    end

    typedef struct {
        logic [DW-1:0] data;
        int            cyc;
    } rd_t;

    typedef struct {
        logic       en;
        logic       push;
        logic [2:0] st;
        logic       aclr;
        logic       rdreq;
    } vec_t;

    int            errors = 0;
    int            checks = 0;
    int            cyc = 0;
    int            vld_seen = 0;
    int            scnt_model = 0;
    logic [DW-1:0] fifo_q[$];
    rd_t           exp_q[$];
    logic          en_cmd = 1'b0, rst_cmd = 1'b0, full_cmd = 1'b0;
    logic          push_cmd = 1'b0, block_cmd = 1'b0;
    logic [DW-1:0] wr_val = 14'd1;
    logic          rd_pend = 1'b0;
    logic [DW-1:0] rd_word = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
        end
    endtask

    // One clock cycle: apply commanded inputs, then sample and score outputs.
    task automatic tick();
        rd_t e;
        @(posedge clk);
        #1;
        cyc++;
        i_rst         = rst_cmd;
        i_en          = en_cmd;
        i_fifo_rdfull = full_cmd;
        if (rd_pend) i_fifo_q = rd_word;
        rd_pend = 1'b0;
        if (push_cmd) begin
            fifo_q.push_back(wr_val);
            wr_val++;
        end
        i_fifo_rdempty = (fifo_q.size() == 0) || block_cmd;
        i_fifo_rdusedw = (fifo_q.size() > 15) ? 4'hF : 4'(fifo_q.size());
        @(negedge clk);
        if (m_vld) begin
            vld_seen++;
            if (exp_q.size() == 0) begin
                check("vld_unexpected", {31'd0, m_vld}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                scnt_model++;
                check("data", {18'd0, m_data}, {18'd0, e.data});
                check("latency", cyc - e.cyc, 2);
                check("sample_cnt", {16'd0, m_scnt}, scnt_model & cnt_mask);
                $display("vld cyc=%0d data=%0h sample_cnt=%0d", cyc, m_data, m_scnt);
            end
        end
        if (m_rdreq) begin
            check("rdreq_while_empty", {31'd0, i_fifo_rdempty}, 32'd0);
            if (!i_fifo_rdempty) begin
                rd_word = fifo_q.pop_front();
                rd_pend = 1'b1;
                exp_q.push_back('{rd_word, cyc});
            end
        end
        if (m_aclr) fifo_q.delete();
        if (i_rst) begin
            exp_q.delete();
            fifo_q.delete();
            rd_pend    = 1'b0;
            scnt_model = 0;
        end
    endtask

    task automatic apply_vec(input vec_t v, input string tag);
        en_cmd   = v.en;
        push_cmd = v.push;
        tick();
        check({tag, "_state"}, {29'd0, m_state}, {29'd0, v.st});
        check({tag, "_aclr"}, {31'd0, m_aclr}, {31'd0, v.aclr});
        check({tag, "_rdreq"}, {31'd0, m_rdreq}, {31'd0, v.rdreq});
        check({tag, "_running"}, {31'd0, m_running}, {31'd0, (v.st == 3'd4)});
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_state"}, {29'd0, m_state}, 32'd0);
        check({tag, "_aclr"}, {31'd0, m_aclr}, 32'd0);
        check({tag, "_vld"}, {31'd0, m_vld}, 32'd0);
        check({tag, "_running"}, {31'd0, m_running}, 32'd0);
        check({tag, "_err"}, {31'd0, m_err}, 32'd0);
        check({tag, "_ovf"}, {16'd0, m_ovf}, 32'd0);
        check({tag, "_scnt"}, {16'd0, m_scnt}, 32'd0);
        check({tag, "_data"}, {18'd0, m_data}, 32'd0);
    endtask

    vec_t t1[18];
    vec_t t5[6];

    initial begin
        int base;
        int aclr_cyc;
        int reached;

        // Start-up table for dut_a: 1 IDLE, 4 CLEAR, 8 SETTLE, then PRIME
        // with usedw rising 1..4, then RUN.
        for (int i = 0; i < 18; i++) begin
            t1[i].en    = 1'b1;
            t1[i].push  = (i >= 13 && i <= 16);
            t1[i].st    = (i == 0) ? 3'd0 : (i <= 4) ? 3'd1 : (i <= 12) ? 3'd2 :
                          (i <= 16) ? 3'd3 : 3'd4;
            t1[i].aclr  = (i >= 1 && i <= 4);
            t1[i].rdreq = (i == 17);
        end
        // dut_b: 1-cycle CLEAR and SETTLE, PRIME exits without data.
        for (int i = 0; i < 6; i++) begin
            t5[i].en    = 1'b1;
            t5[i].push  = (i == 5);
            t5[i].st    = (i >= 4) ? 3'd4 : 3'(i);
            t5[i].aclr  = (i == 1);
            t5[i].rdreq = (i == 5);
        end

        sel = 1'b0;
        i_rst = 1'b1; i_en = 1'b0; i_fifo_q = '0; i_fifo_rdempty = 1'b1;
        i_fifo_rdfull = 1'b0; i_fifo_rdusedw = '0;

        // Reset state
        rst_cmd = 1'b1; tick();
        rst_cmd = 1'b0; tick();
        check_all_zero("reset");
        check("reset_rdreq", {31'd0, m_rdreq}, 32'd0);

        // T1: start-up sequencing
        for (int i = 0; i < 18; i++) apply_vec(t1[i], $sformatf("t1_row%0d", i));

        // T2: stream words 5..10 on top of 1..4 already primed
        base = vld_seen - 0;
        push_cmd = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        push_cmd = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        check("t2_vld_count", vld_seen, 10);
        check("t2_sample_cnt", {16'd0, m_scnt}, 32'd10);
        check("t2_last_data", {18'd0, m_data}, 32'h00A);

        // T3: empty flag toggling every other cycle
        base = vld_seen;
        for (int i = 0; i < 16; i++) begin
            push_cmd  = (i < 6);
            block_cmd = (i % 2 == 0);
            tick();
        end
        push_cmd = 1'b0; block_cmd = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        check("t3_vld_count", vld_seen - base, 6);
        check("t3_fifo_drained", fifo_q.size(), 0);

        // T4: rdfull pulse with auto-recover
        push_cmd = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        push_cmd = 1'b0;
        full_cmd = 1'b1; tick();
        full_cmd = 1'b0;
        aclr_cyc = 0; reached = 0;
        for (int i = 0; i < 40 && reached == 0; i++) begin
            push_cmd = (m_state == 3'd2 || m_state == 3'd3);
            tick();
            if (m_aclr) aclr_cyc++;
            if (m_state == 3'd4) reached = 1;
        end
        push_cmd = 1'b0;
        check("t4_aclr_cycles", aclr_cyc, 4);
        check("t4_rerun", reached, 1);
        check("t4_ovf_cnt", {16'd0, m_ovf}, 32'd1);
        check("t4_running", {31'd0, m_running}, 32'd1);
        for (int i = 0; i < 8; i++) tick();

        // T6a: enable drops with two reads in flight
        push_cmd = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        push_cmd = 1'b0; en_cmd = 1'b0;
        base = vld_seen;
        tick();
        check("t6_rdreq_en_low", {31'd0, m_rdreq}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t6_no_rdreq", {31'd0, m_rdreq}, 32'd0);
            check("t6_idle", {29'd0, m_state}, 32'd0);
        end
        check("t6_trailing_vld", vld_seen - base, 2);

        // T6b: reset in the middle of CLEAR
        en_cmd = 1'b1; tick(); tick();
        check("t6_in_clear", {29'd0, m_state}, 32'd1);
        rst_cmd = 1'b1; tick();
        rst_cmd = 1'b0; tick();
        check_all_zero("t6_rst");
        en_cmd = 1'b0; tick();

        // T5: dut_b, no auto-recover, minimal timings, 3-bit counters
        sel = 1'b1;
        rst_cmd = 1'b1; tick();
        rst_cmd = 1'b0; tick();
        check_all_zero("t5_reset");
        for (int i = 0; i < 6; i++) apply_vec(t5[i], $sformatf("t5_row%0d", i));
        push_cmd = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        push_cmd = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("t5_scnt_wrap", {16'd0, m_scnt}, 32'd3);
        full_cmd = 1'b1; tick();
        full_cmd = 1'b0; tick();
        check("t5_err_state", {29'd0, m_state}, 32'd5);
        check("t5_err_flag", {31'd0, m_err}, 32'd1);
        check("t5_err_running", {31'd0, m_running}, 32'd0);
        push_cmd = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t5_err_no_rdreq", {31'd0, m_rdreq}, 32'd0);
            check("t5_err_hold", {29'd0, m_state}, 32'd5);
        end
        push_cmd = 1'b0;
        check("t5_ovf1", {16'd0, m_ovf}, 32'd1);
        en_cmd = 1'b0; tick(); tick();
        check("t5_en_low_idle", {29'd0, m_state}, 32'd0);
        check("t5_en_low_err", {31'd0, m_err}, 32'd0);
        en_cmd = 1'b1; tick(); tick();
        check("t5_restart_clear", {29'd0, m_state}, 32'd1);
        check("t5_restart_aclr", {31'd0, m_aclr}, 32'd1);
        tick(); tick(); tick();
        check("t5_run_again", {29'd0, m_state}, 32'd4);

        // Simultaneous enable drop and overflow: counted, goes to IDLE
        en_cmd = 1'b0; full_cmd = 1'b1; tick();
        full_cmd = 1'b0; tick();
        check("t5_sim_idle", {29'd0, m_state}, 32'd0);
        check("t5_sim_ovf", {16'd0, m_ovf}, 32'd2);

        // Overflow counter saturation at 7
        for (int k = 0; k < 7; k++) begin
            en_cmd = 1'b1;
            reached = 0;
            for (int j = 0; j < 10 && reached == 0; j++) begin
                tick();
                if (m_state == 3'd4) reached = 1;
            end
            check("t5_sat_run", reached, 1);
            full_cmd = 1'b1; tick();
            full_cmd = 1'b0; en_cmd = 1'b0; tick();
            tick();
            check($sformatf("t5_sat_ovf%0d", k), {16'd0, m_ovf},
                  ((k + 3) > 7) ? 32'd7 : 32'(k + 3));
        end

        for (int i = 0; i < 4; i++) tick();
        check("sb_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
